// File: rtl/balanca_pkg.sv
// balanca_pkg: shared types and constants for the scale price engine.
package balanca_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_RND} state_t;

    localparam int GRAMS_PER_KG = 1000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/divisor_seq.sv
// divisor_seq: restoring divider, one quotient bit per cycle after load.
module divisor_seq
    import balanca_pkg::*;
#(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         valid
);

    localparam int CW = clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [W:0]    trial;
    logic          fits;

    // quotient doubles as the dividend shift register
    always_comb begin
        trial = {remainder, quotient[W-1]};
        fits  = trial >= {1'b0, divisor};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            valid     <= 1'b0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            cnt       <= CW'(W);
            valid     <= 1'b0;
        end else if (cnt != '0) begin
            remainder <= fits ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
            quotient  <= {quotient[W-2:0], fits};
            cnt       <= cnt - CW'(1);
            valid     <= cnt == CW'(1);
        end
    end

endmodule

// File: rtl/preco_multiplicador_seq.sv
// preco_multiplicador_seq: price = round_half_up(weight_g * price_kg / DIVISOR)
// via shift-add multiply, restoring divide, then round and saturate.
module preco_multiplicador_seq
    import balanca_pkg::*;
#(
    parameter int WEIGHT_W = 12,
    parameter int PRICE_W  = 10,
    parameter int OUT_W    = 16,
    parameter int DIVISOR  = GRAMS_PER_KG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WEIGHT_W-1:0] weight_g,
    input  logic [PRICE_W-1:0]  price_kg,
    output logic                busy,
    output logic                done,
    output logic [OUT_W-1:0]    price,
    output logic                ovf
);

    localparam int PROD_W = WEIGHT_W + PRICE_W;
    localparam int CNT_W  = clog2(PROD_W + 1);

    state_t              state, next;
    logic [CNT_W-1:0]    cnt;
    logic [WEIGHT_W-1:0] w_sh;
    logic [PROD_W-1:0]   p_sh, prod, q, r;
    logic [PROD_W:0]     qr;
    logic                div_load, div_valid, sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next;
            cnt   <= (next != state || state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
        end
    end

    // DIV spends one cycle loading the divider, then PROD_W cycles dividing
    always_comb begin
        next = state;
        case (state)
            ST_IDLE: next = start ? ST_MUL : ST_IDLE;
            ST_MUL:  next = (cnt == CNT_W'(WEIGHT_W - 1)) ? ST_DIV : ST_MUL;
            ST_DIV:  next = (cnt == CNT_W'(PROD_W)) ? ST_RND : ST_DIV;
            default: next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = state != ST_IDLE;
        div_load = state == ST_DIV && cnt == '0;
    end

    always_comb begin
        qr  = {1'b0, q} + (PROD_W + 1)'({r, 1'b0} >= (PROD_W + 1)'(DIVISOR));
        sat = |qr[PROD_W:OUT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_sh  <= '0;
            p_sh  <= '0;
            prod  <= '0;
            done  <= 1'b0;
            price <= '0;
            ovf   <= 1'b0;
        end else begin
            done <= state == ST_RND && div_valid;
            if (state == ST_IDLE && start) begin
                w_sh <= weight_g;
                p_sh <= PROD_W'(price_kg);
                prod <= '0;
            end
            if (state == ST_MUL) begin
                prod <= w_sh[0] ? prod + p_sh : prod;
                w_sh <= w_sh >> 1;
                p_sh <= p_sh << 1;
            end
            if (state == ST_RND) begin
                price <= sat ? '1 : qr[OUT_W-1:0];
                ovf   <= sat;
            end
        end
    end

    divisor_seq #(.W(PROD_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (prod),
        .divisor  (PROD_W'(DIVISOR)),
        .quotient (q),
        .remainder(r),
        .valid    (div_valid)
    );

endmodule

// File: tb/tb_preco_multiplicador_seq.sv
// tb_preco_multiplicador_seq: directed vectors plus handshake, back-to-back and reset sequences.
module tb_preco_multiplicador_seq;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [11:0] weight_g = 0;
    logic [9:0]  price_kg = 0;
    logic        busy, done, ovf, busy2, done2, ovf2;
    logic [15:0] price;
    logic [11:0] price2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    preco_multiplicador_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .weight_g(weight_g), .price_kg(price_kg),
        .busy(busy), .done(done), .price(price), .ovf(ovf)
    );

    preco_multiplicador_seq #(.OUT_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .weight_g(weight_g), .price_kg(price_kg),
        .busy(busy2), .done(done2), .price(price2), .ovf(ovf2)
    );

    typedef struct {
        logic [11:0] w;
        logic [9:0]  p;
        int          price;
        bit          ovf;
        int          price12;
        bit          ovf12;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [11:0] w, input logic [9:0] p);
        @(negedge clk);
        start = 1;
        weight_g = w;
        price_kg = p;
        @(posedge clk);
        #1 start = 0;
    endtask

    // entered #1 after the accept edge; returns edges counted until done is seen
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    int lat, bcnt, dones, done_at, got;

    initial begin
        vecs[0] = '{12'd1500, 10'd470,  705,  1'b0, 705,  1'b0};
        vecs[1] = '{12'd499,  10'd1,    0,    1'b0, 0,    1'b0};
        vecs[2] = '{12'd500,  10'd1,    1,    1'b0, 1,    1'b0};
        vecs[3] = '{12'd1,    10'd999,  1,    1'b0, 1,    1'b0};
        vecs[4] = '{12'd4095, 10'd1023, 4189, 1'b0, 4095, 1'b1};
        vecs[5] = '{12'd0,    10'd800,  0,    1'b0, 0,    1'b0};
        vecs[6] = '{12'd1234, 10'd567,  700,  1'b0, 700,  1'b0};
        vecs[7] = '{12'd2000, 10'd999,  1998, 1'b0, 1998, 1'b0};
        vecs[8] = '{12'd1000, 10'd1000, 1000, 1'b0, 1000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset price", price, 0);
        check("reset ovf", ovf, 0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].w, vecs[i].p);
            wait_done(lat, bcnt);
            check($sformatf("v%0d latency", i), lat, 36);
            check($sformatf("v%0d busy cycles", i), bcnt, 36);
            check($sformatf("v%0d busy at done", i), busy, 0);
            check($sformatf("v%0d price", i), price, vecs[i].price);
            check($sformatf("v%0d ovf", i), ovf, vecs[i].ovf);
            check($sformatf("v%0d price12", i), price2, vecs[i].price12);
            check($sformatf("v%0d ovf12", i), ovf2, vecs[i].ovf12);
            @(posedge clk);
            #1 check($sformatf("v%0d done pulse", i), done, 0);
        end

        // starts at cycles 5 and 20 while busy, with operands changing every cycle
        launch(12'd1500, 10'd470);
        dones = 0;
        done_at = 0;
        got = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            start = (i == 5 || i == 20);
            weight_g = 12'(i * 37);
            price_kg = 10'(i * 11);
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                done_at = i;
                got = price;
            end
        end
        start = 0;
        check("ignored starts done count", dones, 1);
        check("ignored starts done at", done_at, 36);
        check("ignored starts price", got, 705);
        check("price held", price, 705);

        // back-to-back: second start asserted during the done cycle
        launch(12'd1, 10'd999);
        wait_done(lat, bcnt);
        check("b2b first price", price, 1);
        start = 1;
        weight_g = 12'd4095;
        price_kg = 10'd1023;
        @(posedge clk);
        #1 start = 0;
        wait_done(lat, bcnt);
        check("b2b latency", lat, 36);
        check("b2b price", price, 4189);
        check("b2b price12", price2, 4095);
        check("b2b ovf12", ovf2, 1);

        // asynchronous reset in the middle of a run
        launch(12'd1000, 10'd1000);
        repeat (14) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst price", price, 0);
        check("midrst ovf", ovf, 0);
        check("midrst price12", price2, 0);
        check("midrst ovf12", ovf2, 0);
        @(negedge clk) rst_n = 1;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check("midrst no done", dones, 0);
        launch(12'd2000, 10'd999);
        wait_done(lat, bcnt);
        check("after reset latency", lat, 36);
        check("after reset price", price, 1998);
        check("after reset ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
